// File: rtl/dino_motion_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : dino_motion_if
//  Purpose  : Signal bundle between the game controller and the dino motion
//             engine. Carries the frame strobe, button levels and game status
//             toward the engine, and the sprite position/status back out.
//  Modports : master - game side (drives controls, observes sprite state)
//             slave  - motion engine (consumes controls, drives sprite state)
//  Signals  : frame_tick  end-of-frame strobe, may be high several clk cycles
//             up / down   jump and duck/fast-fall buttons, level
//             game_on     high once the game has started
//             game_over   high after a collision, until reset
//             dino_x      sprite left edge (constant)
//             dino_y      sprite top edge (registered)
//             airborne    dino is rising or falling
//             ducking     dino is ducking
//             jump_count  take-offs since reset, saturating
//  Revision : 1.0 - initial release
// ============================================================================
interface dino_motion_if;
  logic        frame_tick;
  logic        up;
  logic        down;
  logic        game_on;
  logic        game_over;
  logic [31:0] dino_x;
  logic [31:0] dino_y;
  logic        airborne;
  logic        ducking;
  logic [15:0] jump_count;

  modport master (
    output frame_tick,
    output up,
    output down,
    output game_on,
    output game_over,
    input  dino_x,
    input  dino_y,
    input  airborne,
    input  ducking,
    input  jump_count
  );

  modport slave (
    input  frame_tick,
    input  up,
    input  down,
    input  game_on,
    input  game_over,
    output dino_x,
    output dino_y,
    output airborne,
    output ducking,
    output jump_count
  );
endinterface : dino_motion_if
`default_nettype wire

// File: rtl/dino_motion.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : dino_motion
//  Purpose  : Vertical motion engine for the runner sprite. Once per video
//             frame it advances a small ground/duck/rise/fall state machine
//             with a signed velocity and gravity, clamps landings to the
//             ground line and counts take-offs.
//  Ports    : clk    - system clock, all state updates on its rising edge
//             reset  - asynchronous, active-low
//             bus    - dino_motion_if.slave (controls in, sprite state out)
//  Revision : 1.0 - initial release
// ============================================================================
module dino_motion #(
  parameter int DINO_X       = 50,
  parameter int GROUND_Y     = 275,
  parameter int JUMP_V       = 12,
  parameter int GRAVITY      = 1,
  parameter int FAST_GRAVITY = 3
) (
  input  logic          clk,
  input  logic          reset,
  dino_motion_if.slave  bus
);

  // --------------------------------------------------------------------------
  // Constants sized to the datapath
  // --------------------------------------------------------------------------
  localparam logic        [9:0]  c_GROUND_Y   = 10'(GROUND_Y);
  localparam logic signed [10:0] c_GROUND_Y_S = 11'(GROUND_Y);
  localparam logic signed [7:0]  c_JUMP_V_NEG = -(8'(JUMP_V));
  localparam logic signed [7:0]  c_GRAV       = 8'(GRAVITY);
  localparam logic signed [7:0]  c_FAST_GRAV  = 8'(FAST_GRAVITY);
  localparam logic        [15:0] c_JCNT_MAX   = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_GROUND = 2'd0,
    ST_DUCK   = 2'd1,
    ST_RISE   = 2'd2,
    ST_FALL   = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Frame strobe edge detection
  // --------------------------------------------------------------------------
  // r_ft is the edge register. r_armed only becomes set once frame_tick has
  // been seen low after reset, so a strobe that is already high when reset
  // releases cannot masquerade as a fresh rising edge. r_tick is the
  // registered one-clk pulse; motion updates happen on the edge after the one
  // that first sampled frame_tick high.
  logic r_ft;
  logic r_armed;
  logic r_tick;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ft    <= 1'b0;
      r_armed <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_ft    <= bus.frame_tick;
      r_armed <= r_armed | ~bus.frame_tick;
      r_tick  <= bus.frame_tick & ~r_ft & r_armed;
    end
  end

  // --------------------------------------------------------------------------
  // Motion state
  // --------------------------------------------------------------------------
  state_t             r_state;
  logic signed [7:0]  r_v;
  logic        [9:0]  r_y;
  logic        [15:0] r_jcnt;

  state_t             w_state_nxt;
  logic signed [7:0]  w_v_nxt;
  logic        [9:0]  w_y_nxt;
  logic        [15:0] w_jcnt_nxt;

  logic               w_run;
  logic signed [7:0]  w_g;
  logic signed [7:0]  w_v_sum;
  logic signed [10:0] w_y_sum;
  logic               w_land;
  logic               w_y_neg;

  // Motion only advances on a tick while the game is live; otherwise every
  // piece of state is frozen.
  assign w_run = r_tick & bus.game_on & ~bus.game_over;

  assign w_g     = bus.down ? c_FAST_GRAV : c_GRAV;
  assign w_v_sum = r_v + w_g;

  // Position is unsigned but velocity is signed: widen y by one zero bit and
  // sign-extend v so the sum is a correct signed value (upward moves are
  // negative velocity).
  assign w_y_sum = $signed({1'b0, r_y}) + $signed({{3{r_v[7]}}, r_v});
  assign w_land  = (w_y_sum >= c_GROUND_Y_S);
  assign w_y_neg = w_y_sum[10];

  always_comb begin
    w_state_nxt = r_state;
    w_v_nxt     = r_v;
    w_y_nxt     = r_y;
    w_jcnt_nxt  = r_jcnt;

    if (w_run) begin
      case (r_state)
        ST_GROUND: begin
          // Jump wins over duck when both buttons are pressed.
          if (bus.up) begin
            w_state_nxt = ST_RISE;
            w_v_nxt     = c_JUMP_V_NEG;
            if (r_jcnt != c_JCNT_MAX) begin
              w_jcnt_nxt = r_jcnt + 16'd1;
            end
          end else if (bus.down) begin
            w_state_nxt = ST_DUCK;
          end
        end

        ST_DUCK: begin
          // up is deliberately ignored while ducking.
          if (!bus.down) begin
            w_state_nxt = ST_GROUND;
          end
        end

        ST_RISE,
        ST_FALL: begin
          if (w_land) begin
            // Landing clamps to the ground line on the same tick; a held up
            // button re-launches only on the following tick from ST_GROUND.
            w_state_nxt = ST_GROUND;
            w_v_nxt     = 8'sd0;
            w_y_nxt     = c_GROUND_Y;
          end else begin
            w_y_nxt     = w_y_neg ? 10'd0 : w_y_sum[9:0];
            w_v_nxt     = w_v_sum;
            w_state_nxt = w_v_sum[7] ? ST_RISE : ST_FALL;
          end
        end

        default: begin
          w_state_nxt = ST_GROUND;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_GROUND;
      r_v     <= 8'sd0;
      r_y     <= c_GROUND_Y;
      r_jcnt  <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_v     <= w_v_nxt;
      r_y     <= w_y_nxt;
      r_jcnt  <= w_jcnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs, decoded from registered state only
  // --------------------------------------------------------------------------
  assign bus.dino_x     = 32'(DINO_X);
  assign bus.dino_y     = {22'd0, r_y};
  assign bus.airborne   = (r_state == ST_RISE) || (r_state == ST_FALL);
  assign bus.ducking    = (r_state == ST_DUCK);
  assign bus.jump_count = r_jcnt;

endmodule : dino_motion
`default_nettype wire
